truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Drives the 4-input vector {A,B,C,D} of an external combinational function through all 16 codes in ascending order.
- Samples the function's output Y for each code and builds the 16-bit truth table.
- Compares the table against an expected mask and reports the result.
- Sits beside any 4-in/1-out logic block as its stimulus/capture end, for bring-up and self-test.

Parameters:
- SETTLE_CYC, 2: wait cycles per vector between driving inputs and the sample cycle. Legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request a sweep. Accepted only in IDLE.
- expected  in  16  expected truth table. Bit i is Y for {A,B,C,D}=i. Latched at start accept.
- A  out  1  index bit 3 (MSB) to the function.
- B  out  1  index bit 2.
- C  out  1  index bit 1.
- D  out  1  index bit 0.
- Y  in  1  function output.
- busy  out  1  high from the start accept through the DONE cycle.
- done  out  1  one-cycle pulse when results are valid.
- table_out  out  16  captured truth table.
- mismatch  out  1  table_out differs from the latched expected.
- err_count  out  5  number of mismatched bits, 0..16.
- first_err  out  4  lowest mismatching index. 0 when there is no mismatch.

Behaviour:
- Reset (synchronous, rst_n=0 at an edge):
  - State goes to IDLE and the index goes to 0.
  - {A,B,C,D}=0000; busy=0, done=0.
  - table_out=0, mismatch=0, err_count=0, first_err=0, and the latched expected is cleared.
  - Reset wins over every other event, including mid-sweep. An aborted sweep produces no done pulse.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - Outputs drive 0000.
  - When start=1 at an edge: latch expected; clear table_out, err_count, mismatch and first_err; set index=0 and the settle counter=0.
  - After that edge, go to SETTLE if SETTLE_CYC>0, otherwise to SAMPLE.
- SETTLE:
  - {A,B,C,D}=index. The settle counter increments each cycle.
  - Go to SAMPLE after SETTLE_CYC cycles spent in SETTLE.
- SAMPLE:
  - {A,B,C,D}=index is still driven.
  - At the closing edge, table_out[index] is set to Y.
  - If Y differs from expected[index]: err_count increments. If this is the first error, first_err is set to index.
  - If index<15: index increments, the settle counter clears, and the next state is SETTLE (or SAMPLE when SETTLE_CYC=0).
  - If index=15: go to DONE. The index does not wrap inside a sweep.
- DONE:
  - One cycle. done=1, busy=1.
  - mismatch = (table_out != expected latch).
  - {A,B,C,D} returns to 0000.
  - Next state is IDLE.
- Timing:
  - Each vector occupies SETTLE_CYC+1 cycles.
  - The done pulse occurs exactly 16*(SETTLE_CYC+1)+1 cycles after the start-accept edge.
- start handling:
  - start is level-sampled; holding it high yields back-to-back sweeps separated by one IDLE cycle.
  - start is ignored while busy=1, including during DONE.
- Result persistence:
  - table_out, err_count, first_err and mismatch hold after DONE until the next start accept or reset.
  - During a sweep they show partial results. mismatch stays 0 until DONE.
- Input changes: changes of expected during a sweep have no effect.
- Width rule: err_count saturates naturally at 16; no overflow is possible with 5 bits.

Decomposition:
- Shared package contents:
  - State enum: IDLE, SETTLE, SAMPLE, DONE.
  - Constants TT_W=16, IDX_W=4, ERRC_W=5.
  - Reference mask for the team's majority-plus-A function, FN_MAJ_A_TT = 16'hFFE8.
- One sub-module, sweep_settle_timer:
  - A counter with clear and enable.
  - Outputs an expire flag when the count equals SETTLE_CYC, or immediately when SETTLE_CYC=0.
- The FSM, index register and compare logic stay in the top module.

Test Plan:
- Sweep with SETTLE_CYC=2, Y driven by the bench model A|BC|BD|CD, expected=16'hFFE8, start pulsed once:
  - done arrives 49 cycles after the accept edge.
  - table_out=16'hFFE8, mismatch=0, err_count=0, first_err=0.
- Same sweep with expected=16'hFFE0 (bit 3 wrong) → mismatch=1, err_count=1, first_err=3.
- Y tied to 0 and expected=16'hFFFF → table_out=0, err_count=16, first_err=0, mismatch=1.
- SETTLE_CYC=0 with Y=D and expected=16'hAAAA:
  - ABCD steps one code per cycle.
  - done 17 cycles after accept; table_out=16'hAAAA, mismatch=0.
- rst_n=0 asserted while index=7, then a fresh start:
  - Next cycle, all outputs are at their reset values and no done pulse occurs.
  - The fresh sweep completes correctly.
- start re-pulsed mid-sweep and during DONE → ignored; done timing unchanged. start held high → the second sweep accepts exactly one IDLE cycle after DONE.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_pkg
// Shared types and constants for the truth-table sweeper.
//   state_t      : sweep FSM states (IDLE, SETTLE, SAMPLE, DONE)
//   TT_W         : truth-table width (one bit per 4-bit input code)
//   IDX_W        : width of the input-code index
//   ERRC_W       : width of the mismatch counter (must hold 0..16)
//   FN_MAJ_A_TT  : reference table for Y = A | BC | BD | CD
// -----------------------------------------------------------------------------
package truth_table_sweeper_pkg;

   localparam int TT_W   = 16;
   localparam int IDX_W  = 4;
   localparam int ERRC_W = 5;

   localparam logic [TT_W-1:0] FN_MAJ_A_TT = 16'hFFE8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
// Bundles the sweeper's control, stimulus, capture and result signals.
//   start, expected      : sweep request and expected table (env -> sweeper)
//   A, B, C, D           : 4-bit input code to the function under test
//   Y                    : function output (env -> sweeper)
//   busy, done           : sweep in progress / one-cycle result strobe
//   table_out, mismatch,
//   err_count, first_err : captured table and comparison results
//   dbg_state            : current FSM state, for observation only
// Modports: master = the sweeper, slave = the surrounding environment.
// Handshake: start is a level request sampled only while the sweeper is idle;
// there is no ready signal, so the requester learns of acceptance from busy.
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if;
   import truth_table_sweeper_pkg::*;

   logic              start;
   logic [TT_W-1:0]   expected;
   logic              A;
   logic              B;
   logic              C;
   logic              D;
   logic              Y;
   logic              busy;
   logic              done;
   logic [TT_W-1:0]   table_out;
   logic              mismatch;
   logic [ERRC_W-1:0] err_count;
   logic [IDX_W-1:0]  first_err;
   state_t            dbg_state;

   modport master (
      input  start, expected, Y,
      output A, B, C, D, busy, done, table_out, mismatch, err_count,
             first_err, dbg_state
   );

   modport slave (
      output start, expected, Y,
      input  A, B, C, D, busy, done, table_out, mismatch, err_count,
             first_err, dbg_state
   );

endinterface

// File: rtl/sweep_settle_timer.sv
// -----------------------------------------------------------------------------
// sweep_settle_timer
// Counts cycles spent waiting for the function output to settle.
//   clk, rst_n : clock, synchronous active-low reset
//   i_clr      : clear the count (has priority over i_en)
//   i_en       : count this cycle
//   o_expire   : this enabled cycle is the last settle cycle, i.e. its closing
//                edge brings the count to SETTLE_CYC; constantly high when
//                SETTLE_CYC = 0
// -----------------------------------------------------------------------------
module sweep_settle_timer #(
   parameter int SETTLE_CYC = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   logic [3:0] r_cnt;
   logic [4:0] w_cnt_nxt;

   // One bit wider than the counter so the compare never aliases on wrap.
   assign w_cnt_nxt = {1'b0, r_cnt} + 5'd1;
   assign o_expire  = (SETTLE_CYC == 0) || (i_en && (w_cnt_nxt == 5'(SETTLE_CYC)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= 4'd0;
      end else if (i_clr) begin
         r_cnt <= 4'd0;
      end else if (i_en) begin
         r_cnt <= w_cnt_nxt[3:0];
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Walks {A,B,C,D} through codes 0..15, waits SETTLE_CYC cycles per code,
// samples Y, builds the 16-bit truth table and compares it against the
// expected table latched at start.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : truth_table_sweeper_if.master (control, stimulus, results)
// Parameter SETTLE_CYC (0..15): settle cycles before each sample cycle.
// Each code occupies SETTLE_CYC+1 cycles; DONE is one extra cycle.
// -----------------------------------------------------------------------------
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int SETTLE_CYC = 2
) (
   input  logic clk,
   input  logic rst_n,
   truth_table_sweeper_if.master bus
);

   state_t            r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  r_vec;
   logic [TT_W-1:0]   r_exp;
   logic [TT_W-1:0]   r_table;
   logic [ERRC_W-1:0] r_err;
   logic [IDX_W-1:0]  r_first;
   logic              r_mis;
   logic              r_busy;
   logic              r_done;

   logic              w_expire;
   logic              w_tmr_clr;
   logic              w_tmr_en;
   logic              w_bit_err;
   logic [TT_W-1:0]   w_tbl_nxt;
   state_t            w_vec_state;

   // Timer runs only in SETTLE and restarts from zero for every code.
   assign w_tmr_clr = (r_state == IDLE) || (r_state == SAMPLE);
   assign w_tmr_en  = (r_state == SETTLE);

   sweep_settle_timer #(
      .SETTLE_CYC (SETTLE_CYC)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clr    (w_tmr_clr),
      .i_en     (w_tmr_en),
      .o_expire (w_expire)
   );

   // With no settle time every code goes straight to its sample cycle.
   assign w_vec_state = (SETTLE_CYC > 0) ? SETTLE : SAMPLE;

   assign w_bit_err = (bus.Y != r_exp[r_idx]);

   // Table including the bit being sampled now; used for the final compare
   // so mismatch reflects all 16 bits in the DONE cycle.
   always_comb begin
      w_tbl_nxt        = r_table;
      w_tbl_nxt[r_idx] = bus.Y;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_vec   <= '0;
         r_exp   <= '0;
         r_table <= '0;
         r_err   <= '0;
         r_first <= '0;
         r_mis   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_vec <= '0;
               if (bus.start) begin
                  r_exp   <= bus.expected;
                  r_table <= '0;
                  r_err   <= '0;
                  r_first <= '0;
                  r_mis   <= 1'b0;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= w_vec_state;
               end
            end

            SETTLE: begin
               if (w_expire) begin
                  r_state <= SAMPLE;
               end
            end

            SAMPLE: begin
               r_table <= w_tbl_nxt;
               if (w_bit_err) begin
                  r_err <= r_err + 5'd1;
                  if (r_err == '0) begin
                     r_first <= r_idx;
                  end
               end
               if (r_idx != 4'hF) begin
                  r_idx   <= r_idx + 4'd1;
                  r_vec   <= r_idx + 4'd1;
                  r_state <= w_vec_state;
               end else begin
                  // Index stays at 15; the inputs return to 0000 for DONE.
                  r_mis   <= (w_tbl_nxt != r_exp);
                  r_done  <= 1'b1;
                  r_vec   <= '0;
                  r_state <= DONE;
               end
            end

            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.A         = r_vec[3];
   assign bus.B         = r_vec[2];
   assign bus.C         = r_vec[1];
   assign bus.D         = r_vec[0];
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.table_out = r_table;
   assign bus.mismatch  = r_mis;
   assign bus.err_count = r_err;
   assign bus.first_err = r_first;
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Two sweepers share one clock/reset: instance 0 with SETTLE_CYC=2,
// instance 1 with SETTLE_CYC=0. Y is produced from a bench-held truth table
// indexed by {A,B,C,D}. Expected results come from the function table and
// the expected mask (xor, popcount, lowest set bit).
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;
   import truth_table_sweeper_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- DUTs ----------------
   truth_table_sweeper_if u_if0 ();
   truth_table_sweeper_if u_if1 ();

   truth_table_sweeper #(.SETTLE_CYC(2)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if0.master)
   );

   truth_table_sweeper #(.SETTLE_CYC(0)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if1.master)
   );

   logic        start_s [2];
   logic [15:0] exp_s   [2];
   logic [15:0] fn_s    [2];

   assign u_if0.start    = start_s[0];
   assign u_if0.expected = exp_s[0];
   assign u_if0.Y        = fn_s[0][{u_if0.A, u_if0.B, u_if0.C, u_if0.D}];
   assign u_if1.start    = start_s[1];
   assign u_if1.expected = exp_s[1];
   assign u_if1.Y        = fn_s[1][{u_if1.A, u_if1.B, u_if1.C, u_if1.D}];

   logic [3:0]  vec_o   [2];
   logic        busy_o  [2];
   logic        done_o  [2];
   logic        mis_o   [2];
   logic [15:0] tbl_o   [2];
   logic [4:0]  errc_o  [2];
   logic [3:0]  first_o [2];
   state_t      st_o    [2];

   assign vec_o[0]   = {u_if0.A, u_if0.B, u_if0.C, u_if0.D};
   assign busy_o[0]  = u_if0.busy;
   assign done_o[0]  = u_if0.done;
   assign mis_o[0]   = u_if0.mismatch;
   assign tbl_o[0]   = u_if0.table_out;
   assign errc_o[0]  = u_if0.err_count;
   assign first_o[0] = u_if0.first_err;
   assign st_o[0]    = u_if0.dbg_state;
   assign vec_o[1]   = {u_if1.A, u_if1.B, u_if1.C, u_if1.D};
   assign busy_o[1]  = u_if1.busy;
   assign done_o[1]  = u_if1.done;
   assign mis_o[1]   = u_if1.mismatch;
   assign tbl_o[1]   = u_if1.table_out;
   assign errc_o[1]  = u_if1.err_count;
   assign first_o[1] = u_if1.first_err;
   assign st_o[1]    = u_if1.dbg_state;

   // ---------------- scoreboard ----------------
   int          n_cmp = 0;
   int          n_mis = 0;
   logic [15:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Y = A | BC | BD | CD evaluated for every code.
   function automatic logic [15:0] maj_a_tt();
      logic [15:0] t;
      logic [3:0]  v;
      t = '0;
      for (int i = 0; i < 16; i++) begin
         v = 4'(i);
         t[v] = v[3] | (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      end
      return t;
   endfunction

   task automatic chk_reset(input bit sel, input string pfx);
      chk({pfx, "_vec"},   32'(vec_o[sel]),   0);
      chk({pfx, "_busy"},  32'(busy_o[sel]),  0);
      chk({pfx, "_done"},  32'(done_o[sel]),  0);
      chk({pfx, "_tbl"},   32'(tbl_o[sel]),   0);
      chk({pfx, "_mis"},   32'(mis_o[sel]),   0);
      chk({pfx, "_errc"},  32'(errc_o[sel]),  0);
      chk({pfx, "_first"}, 32'(first_o[sel]), 0);
      chk({pfx, "_state"}, 32'(st_o[sel]),    32'(IDLE));
   endtask

   // One full sweep. Cycle 1 is the cycle right after the accept edge.
   // hold:     leave start high (caller checks the back-to-back accept)
   // poke:     re-pulse start / change expected mid-sweep and during DONE
   // accepted: the accept edge already happened; we are in cycle 1
   task automatic sweep(input bit sel, input logic [15:0] fn, input logic [15:0] exp,
                        input bit hold, input bit poke, input bit accepted);
      int          s;
      int          len;
      int          n;
      int          poke_at;
      int          e_cnt;
      int          e_first;
      bit          seen;
      logic [15:0] diff;
      logic [15:0] want_tbl;
      s   = sel ? 0 : 2;
      len = 16 * (s + 1);
      diff    = fn ^ exp;
      e_cnt   = $countones(diff);
      e_first = 0;
      for (int i = 15; i >= 0; i--) if (diff[4'(i)]) e_first = i;
      exp_q.push_back(fn);
      if (!accepted) begin
         fn_s[sel]    = fn;
         exp_s[sel]   = exp;
         start_s[sel] = 1'b1;
         tick();
      end
      if (!hold) start_s[sel] = 1'b0;
      poke_at = $urandom_range(3, len - 3);
      n = 1;
      seen = 0;
      while (!seen && n <= len + 8) begin
         if (done_o[sel]) begin
            seen = 1;
         end else begin
            if (n <= len) chk("vec_step", 32'(vec_o[sel]), (n - 1) / (s + 1));
            chk("busy_mid", 32'(busy_o[sel]), 1);
            chk("mis_mid", 32'(mis_o[sel]), 0);
            if (poke && n == poke_at) begin
               start_s[sel] = 1'b1;
               exp_s[sel]   = 16'($urandom);
            end else if (poke && n == poke_at + 1) begin
               start_s[sel] = 1'b0;
            end
            tick();
            n++;
         end
      end
      chk("done_cycle", n, len + 1);
      want_tbl = exp_q.pop_front();
      chk("table_out", 32'(tbl_o[sel]), 32'(want_tbl));
      chk("mismatch", 32'(mis_o[sel]), (diff != 0) ? 1 : 0);
      chk("err_count", 32'(errc_o[sel]), e_cnt);
      chk("first_err", 32'(first_o[sel]), e_first);
      chk("done_vec", 32'(vec_o[sel]), 0);
      chk("done_busy", 32'(busy_o[sel]), 1);
      if (poke) begin
         start_s[sel] = 1'b1;
         tick();
         chk("done_start_ign", 32'(busy_o[sel]), 0);
         start_s[sel] = 1'b0;
         tick();
         chk("idle_busy", 32'(busy_o[sel]), 0);
         chk("hold_tbl", 32'(tbl_o[sel]), 32'(want_tbl));
      end else if (!hold) begin
         tick();
         chk("idle_busy", 32'(busy_o[sel]), 0);
         chk("idle_done", 32'(done_o[sel]), 0);
         chk("hold_tbl", 32'(tbl_o[sel]), 32'(want_tbl));
         chk("hold_errc", 32'(errc_o[sel]), e_cnt);
         chk("hold_mis", 32'(mis_o[sel]), (diff != 0) ? 1 : 0);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] fn;
      logic [15:0] m;
      logic [15:0] maj;
      int          guard;
      int          done_cnt;
      bit          sel;
      bit          pk;

      for (int k = 0; k < 2; k++) begin
         start_s[k] = 1'b0;
         exp_s[k]   = '0;
         fn_s[k]    = '0;
      end
      rst_n = 1'b0;
      tick();
      tick();
      chk_reset(1'b0, "rst0");
      chk_reset(1'b1, "rst1");
      rst_n = 1'b1;
      tick();

      maj = maj_a_tt();

      // directed sweeps
      sweep(1'b0, maj, 16'hFFE8, 0, 0, 0);
      sweep(1'b0, maj, 16'hFFE0, 0, 0, 0);
      sweep(1'b0, 16'h0000, 16'hFFFF, 0, 0, 0);
      sweep(1'b1, 16'hAAAA, 16'hAAAA, 0, 0, 0);

      // start re-pulsed mid-sweep and during DONE
      sweep(1'b0, maj, 16'hFFE8, 0, 1, 0);
      sweep(1'b1, 16'($urandom), 16'($urandom), 0, 1, 0);

      // start held high: second sweep accepted one IDLE cycle after DONE
      sweep(1'b1, maj, 16'hFFE8, 1, 0, 0);
      tick();
      chk("b2b_idle", 32'(busy_o[1]), 0);
      tick();
      chk("b2b_accept", 32'(busy_o[1]), 1);
      sweep(1'b1, maj, 16'hFFE8, 0, 0, 1);

      // reset while index = 7
      fn = 16'($urandom);
      fn_s[0]    = fn;
      exp_s[0]   = ~fn;
      start_s[0] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      guard = 0;
      while (vec_o[0] != 4'd7 && guard < 100) begin
         tick();
         guard++;
      end
      chk("abort_reach7", 32'(vec_o[0]), 7);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_reset(1'b0, "abort");
      done_cnt = 0;
      for (int c = 0; c < 60; c++) begin
         if (done_o[0]) done_cnt++;
         tick();
      end
      chk("abort_no_done", done_cnt, 0);
      sweep(1'b0, maj, 16'hFFE8, 0, 0, 0);

      // randomized sweeps
      for (int it = 0; it < 10; it++) begin
         sel = 1'($urandom_range(0, 1));
         pk  = 1'($urandom_range(0, 1));
         fn  = 16'($urandom);
         m   = ($urandom_range(0, 3) == 0) ? 16'h0000
                                           : 16'($urandom & $urandom & $urandom);
         sweep(sel, fn, fn ^ m, 0, pk, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
